link_arbiter_mpi: RTL and testbench
===================================

// Module: link_arbiter_mpi
// PURPOSE
//  Shares one credit-based 64-bit link (valid_o/data_o, yummy_i return) among NUM_REQ requesters.
//  Round-robin arbitration at packet granularity: a winner holds the link until its last flit.
//  Owns the link credit counter; sits between rank-local traffic sources and the MPI link sender.
// PARAMETERS
//  NUM_REQ     4             number of requesters (>=2)
//  CREDITS     LINK_CREDITS  initial/maximum link credits (package constant, 7)
// PORTS
//  clk_i         in   1               clock; single clock domain
//  rstn_i        in   1               reset, asynchronous, active-low
//  req_valid_i   in   NUM_REQ         requester i presents a flit
//  req_data_i    in   NUM_REQ x 64    flit payload per requester
//  req_last_i    in   NUM_REQ         flit is last of packet (1-flit packet: last=1)
//  req_ready_o   out  NUM_REQ         flit accepted this cycle when valid&ready
//  yummy_i       in   1               one credit returned by receiver
//  valid_o       out  1               link flit valid (registered)
//  data_o        out  64              link flit, 0 when valid_o=0
//  credit_o      out  CREDIT_WIDTH    current credit count
//  owner_o       out  $clog2(NUM_REQ) current/last granted requester
//  err_o         out  1               sticky: yummy_i with credits already at CREDITS
// BEHAVIOUR
//  Reset (async, rstn_i=0): state=ARB, credit=CREDITS, rr pointer=0, owner=0, valid_o=0,
//   data_o=0, req_ready_o=0, err_o=0. Mid-packet reset abandons packet; no flit emitted after.
//  FSM ARB: if credit_q!=0 and any req_valid_i, grant = first valid at/after rr pointer;
//   req_ready_o[grant]=1 (one-hot, same cycle, combinational from registered state + valids).
//   Accept with last=1 -> stay ARB, pointer=grant+1 (mod NUM_REQ). last=0 -> LOCKED, owner=grant.
//  FSM LOCKED: only owner may be ready; ready=req_valid_i[owner] & (credit_q!=0). Other requesters
//   ready=0 regardless of valid. Accept with last=1 -> ARB, pointer=owner+1. Owner valid low: hold.
//  Credit 0: no ready to anyone; FSM holds state. No same-cycle yummy bypass (credit_q only).
//  Latency: accepted flit appears on data_o/valid_o exactly 1 cycle after acceptance; valid_o=1
//   for exactly one cycle per accepted flit; back-to-back accepts give back-to-back valid_o.
//  Credit update: credit_d = credit_q - accept + yummy_i; accept&yummy same cycle -> unchanged.
//   yummy_i at credit_q==CREDITS (no accept): count holds, err_o set until reset.
//  Arithmetic: CREDIT_WIDTH-bit unsigned, never wraps; CREDITS must fit CREDIT_WIDTH.
//  owner_o = grant index in cycle of accept, registered; holds when idle.
//  Pointer wrap: NUM_REQ-1 + 1 -> 0. Non-power-of-two NUM_REQ supported.
// STRUCTURE
//  metro_mpi_pkg: CREDIT_WIDTH (existing), LINK_CREDITS=7, typedef logic [63:0] flit_t,
//   typedef enum logic {ARB, LOCKED} link_arb_state_e.
//  Sub-module rr_arbiter_mpi: combinational round-robin picker (req vector, pointer ->
//   one-hot grant + index + any). Credit counter, FSM, output register in top.
// TESTING
//  Single requester 0, 10 one-flit packets, no yummy -> 7 flits out (data in order), then
//   ready=0, credit_o=0; 3 yummies -> exactly 3 more flits, each 1 cycle after accept.
//  All 4 valid, one-flit packets, yummy every cycle -> grant order 0,1,2,3,0,...; credit_o stays 7.
//  Req1 3-flit packet while req2 valid -> flits 1a,1b,1c contiguous; req2 ready only after 1c.
//  Credits hit 0 mid-packet in LOCKED -> owner ready drops, state held; yummy -> resumes same owner.
//  Accept and yummy same cycle at credit 3 -> credit_o stays 3; yummy at credit 7 -> err_o=1, 7 held.
//  Assert rstn_i mid-packet -> valid_o=0, credit_o=7, state ARB next cycle after release, err_o=0.

Source files
------------

// File: rtl/metro_mpi_pkg.sv
// Shared types and constants for the MPI link path.
// No logic; widths and credit budget for the link arbiter.
// Credit count is sized so LINK_CREDITS fits without wrap.
package metro_mpi_pkg;

    // Width of the link credit counter.
    localparam int CREDIT_WIDTH = 4;

    // Receiver buffer depth in flits, i.e. initial/maximum link credits.
    localparam int LINK_CREDITS = 7;

    typedef logic [63:0] flit_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } link_arb_state_e;

endpackage

// File: rtl/rr_arbiter_mpi.sv
// Round-robin picker: first requester at or after the pointer wins.
// Latency: purely combinational.
// Backpressure: none; caller masks requests it cannot serve.
module rr_arbiter_mpi #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    // Scan N slots starting at the pointer; the first set request is granted.
    always_comb begin
        int   w_idx;
        logic w_found;
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt[w_idx]   = 1'b1;
                o_gnt_idx      = IW'(w_idx);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/link_arbiter_mpi.sv
// Packet-granular round-robin sharing of one credit-based 64-bit link.
// Latency: accepted flit appears on valid_o/data_o exactly 1 cycle later.
// Backpressure: ready only while credits remain; a packet owner keeps the link until last.
module link_arbiter_mpi
    import metro_mpi_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CREDITS = LINK_CREDITS,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0][63:0]      req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          yummy_i,
    output logic                          valid_o,
    output logic [63:0]                   data_o,
    output logic [CREDIT_WIDTH-1:0]       credit_o,
    output logic [IW-1:0]                 owner_o,
    output logic                          err_o
);

    link_arb_state_e         r_state;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_owner;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic                    r_valid;
    flit_t                   r_data;
    logic                    r_err;

    logic [NUM_REQ-1:0]      w_arb_req;
    logic [NUM_REQ-1:0]      w_arb_gnt;
    logic [NUM_REQ-1:0]      w_ready;
    logic [IW-1:0]           w_arb_idx;
    logic [IW-1:0]           w_sel;
    logic [IW-1:0]           w_ptr_next;
    logic                    w_arb_any;
    logic                    w_can_send;
    logic                    w_accept;
    logic                    w_last;

    // Only registered credits gate sending; a same-cycle yummy is not bypassed.
    assign w_can_send = (r_credit != '0);
    assign w_arb_req  = req_valid_i & {NUM_REQ{w_can_send}};

    rr_arbiter_mpi #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .i_req     (w_arb_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    // Ready is the arbiter grant when free, otherwise only the packet owner.
    always_comb begin
        w_ready = '0;
        if (r_state == ARB) begin
            w_ready = w_arb_gnt;
        end else begin
            w_ready[r_owner] = req_valid_i[r_owner] & w_can_send;
        end
    end

    // Nobody is ready while reset is held, even with requests pending.
    assign req_ready_o = w_ready & {NUM_REQ{rstn_i}};
    assign w_accept    = (r_state == ARB) ? w_arb_any : w_ready[r_owner];
    assign w_sel       = (r_state == ARB) ? w_arb_idx : r_owner;
    assign w_last      = req_last_i[w_sel];
    assign w_ptr_next  = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);

    // Packet-level FSM: lock on a non-last flit, release and advance pointer on last.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_accept) begin
            r_owner <= w_sel;
            if (w_last) begin
                r_state <= ARB;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state <= LOCKED;
            end
        end
    end

    // Credit counter; a yummy arriving with a full counter is a protocol error, count holds.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_credit <= CREDIT_WIDTH'(CREDITS);
            r_err    <= 1'b0;
        end else if (yummy_i && !w_accept && (r_credit == CREDIT_WIDTH'(CREDITS))) begin
            r_err    <= 1'b1;
        end else if (w_accept && !yummy_i) begin
            r_credit <= r_credit - CREDIT_WIDTH'(1);
        end else if (yummy_i && !w_accept) begin
            r_credit <= r_credit + CREDIT_WIDTH'(1);
        end
    end

    // Link output register; data is forced to zero on idle cycles.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_accept;
            r_data  <= w_accept ? req_data_i[w_sel] : '0;
        end
    end

    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign credit_o = r_credit;
    assign owner_o  = r_owner;
    assign err_o    = r_err;

endmodule

// File: tb/tb_link_arbiter_mpi.sv
// Directed bench for link_arbiter_mpi with a reference model and flit scoreboard.
// Accepted flits are queued when the model predicts acceptance and popped when valid_o rises.
// Scenario-level checks cover grant order, credit exhaustion, errors and mid-packet reset.
module tb_link_arbiter_mpi;
    import metro_mpi_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                    clk_i = 1'b0;
    logic                    rstn_i;
    logic [N-1:0]            req_valid_i;
    logic [N-1:0][63:0]      req_data_i;
    logic [N-1:0]            req_last_i;
    logic [N-1:0]            req_ready_o;
    logic                    yummy_i;
    logic                    valid_o;
    logic [63:0]             data_o;
    logic [CREDIT_WIDTH-1:0] credit_o;
    logic [IW-1:0]           owner_o;
    logic                    err_o;

    link_arbiter_mpi #(.NUM_REQ(N), .CREDITS(LINK_CREDITS)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .yummy_i     (yummy_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .credit_o    (credit_o),
        .owner_o     (owner_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int    checks = 0;
    int    errors = 0;
    flit_t sb_q[$];
    int    grant_log[$];
    int    flits_out = 0;

    // Reference model state
    logic  m_locked;
    int    m_ptr;
    int    m_owner;
    int    m_credit;
    logic  m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_credit = LINK_CREDITS;
        m_err    = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle: predict ready, score acceptance, then check registered outputs.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int           g;
        logic         acc;
        for (int r = 0; r < N; r++)
            req_data_i[r] = {32'(r + 1), 32'(grant_log.size())};
        #2;
        exp_rdy = '0;
        g = -1;
        if (m_credit != 0) begin
            if (m_locked) begin
                if (req_valid_i[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", req_ready_o, exp_rdy);
        acc = (g >= 0);
        if (acc) begin
            sb_q.push_back(req_data_i[g]);
            grant_log.push_back(g);
            m_owner = g;
            if (req_last_i[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
            end
        end
        if (yummy_i && !acc && m_credit == LINK_CREDITS) m_err = 1'b1;
        else m_credit = m_credit - int'(acc) + int'(yummy_i);
        @(posedge clk_i);
        #1;
        chk("valid", valid_o, acc);
        if (acc) begin
            chk("data", data_o, sb_q.pop_front());
            flits_out++;
        end else begin
            chk("data_idle", data_o, 64'h0);
        end
        chk("credit", credit_o, m_credit);
        chk("owner", owner_o, m_owner);
        chk("err", err_o, m_err);
    endtask

    initial begin
        int base;
        int exp_rr[8];
        exp_rr = '{1, 2, 3, 0, 1, 2, 3, 0};

        // Reset with requests pending: nobody ready, outputs at reset values.
        rstn_i      = 1'b0;
        req_valid_i = '1;
        req_last_i  = '1;
        req_data_i  = '0;
        yummy_i     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", req_ready_o, 4'b0000);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 64'h0);
        chk("rst_credit", credit_o, 7);
        chk("rst_owner", owner_o, 0);
        chk("rst_err", err_o, 1'b0);
        rstn_i      = 1'b1;
        req_valid_i = '0;

        // Single requester, one-flit packets, no credit return: exactly 7 flits.
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0001;
        repeat (12) cycle();
        chk("s1_flits7", flits_out, 7);
        chk("s1_credit0", credit_o, 0);
        repeat (3) begin
            yummy_i = 1'b1;
            cycle();
            yummy_i = 1'b0;
            cycle();
        end
        chk("s1_flits10", flits_out, 10);
        req_valid_i = '0;

        // Refill credits to the maximum.
        yummy_i = 1'b1;
        repeat (7) cycle();
        chk("refill_credit", credit_o, 7);

        // All requesters valid, yummy every cycle: rotation continues from pointer 1.
        req_valid_i = 4'b1111;
        req_last_i  = 4'b1111;
        base = grant_log.size();
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) chk("s2_rr_order", grant_log[base + i], exp_rr[i]);
        chk("s2_credit7", credit_o, 7);
        yummy_i = 1'b0;

        // Req1 three-flit packet with req2 waiting: 1a,1b,1c then req2.
        req_valid_i = 4'b0110;
        base = grant_log.size();
        req_last_i = 4'b0100; cycle();
        chk("s3_locked_r2_blocked", req_ready_o[2], 1'b0);
        cycle();
        req_last_i = 4'b0110; cycle();
        req_valid_i = 4'b0100; cycle();
        chk("s3_g0", grant_log[base], 1);
        chk("s3_g1", grant_log[base + 1], 1);
        chk("s3_g2", grant_log[base + 2], 1);
        chk("s3_g3", grant_log[base + 3], 2);
        chk("s3_credit3", credit_o, 3);

        // Accept and yummy in the same cycle at credit 3: count unchanged.
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0001;
        yummy_i     = 1'b1;
        cycle();
        chk("acc_yummy_credit3", credit_o, 3);
        yummy_i     = 1'b0;

        // Req3 long packet exhausts credits while locked; req1 must stay blocked.
        req_valid_i = 4'b1000;
        req_last_i  = 4'b0000;
        cycle();
        req_valid_i = 4'b1010;
        repeat (2) cycle();
        chk("s4_credit0", credit_o, 0);
        repeat (2) cycle();
        chk("s4_owner_held", owner_o, 3);
        yummy_i = 1'b1; cycle();
        yummy_i = 1'b0; cycle();
        chk("s4_resume_owner", grant_log[grant_log.size() - 1], 3);
        req_last_i = 4'b1010;
        yummy_i = 1'b1; cycle();
        yummy_i = 1'b0; cycle();
        yummy_i = 1'b1; cycle();
        yummy_i = 1'b0; cycle();
        chk("s4_next_r1", grant_log[grant_log.size() - 1], 1);
        req_valid_i = '0;

        // Refill, then one yummy too many: err sticky, count held at 7.
        yummy_i = 1'b1;
        repeat (7) cycle();
        cycle();
        chk("err_set", err_o, 1'b1);
        chk("err_credit7", credit_o, 7);
        yummy_i = 1'b0;
        cycle();
        chk("err_sticky", err_o, 1'b1);

        // Reset in the middle of a req2 packet.
        req_valid_i = 4'b0100;
        req_last_i  = 4'b0000;
        repeat (2) cycle();
        rstn_i = 1'b0;
        #1;
        chk("mrst_valid", valid_o, 1'b0);
        chk("mrst_credit", credit_o, 7);
        chk("mrst_err", err_o, 1'b0);
        chk("mrst_ready", req_ready_o, 4'b0000);
        @(posedge clk_i);
        #1;
        chk("mrst_no_flit", valid_o, 1'b0);
        chk("mrst_data", data_o, 64'h0);
        rstn_i = 1'b1;
        model_reset();
        req_valid_i = 4'b0110;
        cycle();
        chk("mrst_arb_grant", grant_log[grant_log.size() - 1], 1);
        req_valid_i = '0;
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
